// File: rtl/input_frame_loader.sv
// Double-buffered frame loader: words in on trigger, single bits out by address.
// One bank fills while the consumer reads the other; release hands banks over.
module input_frame_loader #(
    parameter int DATA_W   = 8,
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data,
    input  logic              abort,
    input  logic              rel,
    input  logic [ADDR_W-1:0] addr,
    output logic              q,
    output logic              ready,
    output logic              full,
    output logic              overflow
);

    localparam int WORDS = NUM_BITS / DATA_W;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [WC_W-1:0] LAST = WC_W'(WORDS - 1);

    logic [DATA_W-1:0] mem [2][WORDS];

    logic [WC_W-1:0]   wcnt;
    logic [1:0]        fcnt;
    logic [1:0]        fcnt_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic              we;
    logic              done;
    logic              rel_ok;
    logic              in_range;
    logic [ADDR_W-1:0] rd_word;
    logic [BIT_W-1:0]  rd_bit;

    // Write qualification, frame completion and next frame count
    always_comb begin
        we       = trigger && !full && !abort;
        done     = we && (wcnt == LAST);
        rel_ok   = rel && (fcnt != 2'd0);
        fcnt_nxt = fcnt + {1'b0, done} - {1'b0, rel_ok};
    end

    // Split the bit address into word index and bit-within-word (LSB first)
    always_comb begin
        rd_word  = addr / ADDR_W'(DATA_W);
        rd_bit   = BIT_W'(addr % ADDR_W'(DATA_W));
        in_range = {1'b0, addr} < (ADDR_W + 1)'(NUM_BITS);
    end

    // Bank storage is not reset; stale words are simply overwritten
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_bank][wcnt] <= data;
    end

    // Word counter, bank pointers, frame count and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= '0;
            fcnt     <= 2'd0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            ready    <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (abort)
                wcnt <= '0;
            else if (we)
                wcnt <= done ? '0 : wcnt + WC_W'(1);
            if (done)
                wr_bank <= ~wr_bank;
            if (rel_ok)
                rd_bank <= ~rd_bank;
            fcnt     <= fcnt_nxt;
            ready    <= (fcnt_nxt != 2'd0);
            full     <= (fcnt_nxt == 2'd2);
            overflow <= trigger && full && !abort;
        end
    end

    // Registered bit read from the bank selected before any release this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 1'b0;
        else if (in_range)
            q <= mem[rd_bank][rd_word[WC_W-1:0]][rd_bit];
        else
            q <= 1'b0;
    end

endmodule

// File: tb/tb_input_frame_loader.sv
// Scoreboard bench for input_frame_loader: driver queues expected results,
// a negedge monitor pops and compares them after the edge they belong to.
module tb_input_frame_loader;

    logic       clk;
    logic       rst_n;
    logic       trigger;
    logic [7:0] data;
    logic       abort;
    logic       rel;
    logic [9:0] addr;
    logic       q;
    logic       ready;
    logic       full;
    logic       overflow;

    input_frame_loader #(
        .DATA_W  (8),
        .NUM_BITS(784),
        .ADDR_W  (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .data    (data),
        .abort   (abort),
        .rel     (rel),
        .addr    (addr),
        .q       (q),
        .ready   (ready),
        .full    (full),
        .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    logic       qq[$];
    logic [9:0] qa[$];
    logic [2:0] sq[$];
    logic       rd_pend = 1'b0;
    logic       st_pend = 1'b0;
    logic       rd_d = 1'b0;
    logic       st_d = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        rd_d <= rd_pend;
        st_d <= st_pend;
    end

    always @(negedge clk) begin
        if (rd_d === 1'b1) begin
            if (qq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q_sb: got read with no expectation expected entry");
            end else begin
                logic       e;
                logic [9:0] a;
                e = qq.pop_front();
                a = qa.pop_front();
                chk($sformatf("q@%0d", a), {2'b00, q}, {2'b00, e});
            end
        end
        if (st_d === 1'b1) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL st_sb: got status with no expectation expected entry");
            end else begin
                logic [2:0] e;
                e = sq.pop_front();
                chk("rdy_full_ovf", {ready, full, overflow}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        trigger = 1'b0;
        abort   = 1'b0;
        rel     = 1'b0;
        rd_pend = 1'b0;
        st_pend = 1'b0;
    endtask

    task automatic exp_q(input logic [9:0] a, input logic v);
        addr    = a;
        rd_pend = 1'b1;
        qq.push_back(v);
        qa.push_back(a);
    endtask

    task automatic exp_st(input logic r, input logic f, input logic o);
        st_pend = 1'b1;
        sq.push_back({r, f, o});
    endtask

    task automatic rd(input logic [9:0] a, input logic v);
        exp_q(a, v);
        tick();
    endtask

    task automatic load(input int n, input logic [7:0] d,
                        input logic [1:0] mid, input logic [1:0] last,
                        input logic rel_last);
        for (int i = 0; i < n; i++) begin
            trigger = 1'b1;
            data    = d;
            if (i == n - 1) begin
                rel = rel_last;
                exp_st(last[1], last[0], 1'b0);
            end else begin
                exp_st(mid[1], mid[0], 1'b0);
            end
            tick();
        end
    endtask

    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        chk(name, {ready, full, overflow}, 3'b000);
        chk({name, "_q"}, {2'b00, q}, 3'b000);
        trigger = 1'b1;
        rel     = 1'b1;
        abort   = 1'b1;
        data    = 8'h5A;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        trigger = 1'b1;
        rel     = 1'b1;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n   = 1'b1;
        trigger = 1'b0;
        data    = 8'h00;
        abort   = 1'b0;
        rel     = 1'b0;
        addr    = 10'd0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_status", {ready, full, overflow}, 3'b000);
        chk("reset_q", {2'b00, q}, 3'b000);
        trigger = 1'b1;
        data    = 8'hFF;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        trigger = 1'b1;
        rel     = 1'b1;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        load(98, 8'hFF, 2'b00, 2'b10, 1'b0);
        for (int a = 0; a < 784; a++)
            rd(10'(a), 1'b1);
        rd(10'd784, 1'b0);

        rel = 1'b1;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();

        load(98, 8'hA5, 2'b00, 2'b10, 1'b0);
        rd(10'd0, 1'b1);
        rd(10'd1, 1'b0);
        rd(10'd2, 1'b1);
        rd(10'd3, 1'b0);
        rd(10'd5, 1'b1);
        rd(10'd6, 1'b0);
        rd(10'd7, 1'b1);
        rd(10'd8, 1'b1);
        rd(10'd782, 1'b0);
        rd(10'd783, 1'b1);
        rd(10'd784, 1'b0);
        rd(10'd1023, 1'b0);

        rel = 1'b1;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        load(98, 8'h00, 2'b00, 2'b10, 1'b0);
        load(98, 8'hFF, 2'b10, 2'b11, 1'b0);
        trigger = 1'b1;
        data    = 8'h55;
        exp_st(1'b1, 1'b1, 1'b1);
        tick();
        exp_st(1'b1, 1'b1, 1'b0);
        exp_q(10'd0, 1'b0);
        tick();
        rd(10'd783, 1'b0);
        rel = 1'b1;
        exp_st(1'b1, 1'b0, 1'b0);
        exp_q(10'd0, 1'b0);
        tick();
        rd(10'd0, 1'b1);
        rd(10'd783, 1'b1);

        load(98, 8'h3C, 2'b10, 2'b11, 1'b0);
        rel = 1'b1;
        exp_st(1'b1, 1'b0, 1'b0);
        tick();
        rd(10'd0, 1'b0);
        rd(10'd1, 1'b0);
        rd(10'd2, 1'b1);
        rd(10'd5, 1'b1);
        rd(10'd6, 1'b0);
        rd(10'd7, 1'b0);

        load(98, 8'hC3, 2'b10, 2'b10, 1'b1);
        rd(10'd0, 1'b1);
        rd(10'd2, 1'b0);
        rd(10'd7, 1'b1);

        rel = 1'b1;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        load(50, 8'hAA, 2'b00, 2'b00, 1'b0);
        abort   = 1'b1;
        trigger = 1'b1;
        data    = 8'hAA;
        exp_st(1'b0, 1'b0, 1'b0);
        tick();
        load(98, 8'h0F, 2'b00, 2'b10, 1'b0);
        for (int a = 0; a < 8; a++)
            rd(10'(a), (a < 4) ? 1'b1 : 1'b0);
        rd(10'd87, 1'b0);
        rd(10'd393, 1'b1);
        rd(10'd783, 1'b0);

        load(30, 8'h11, 2'b10, 2'b10, 1'b0);
        tick();
        async_reset("rst_midframe");

        load(98, 8'hFF, 2'b00, 2'b10, 1'b0);
        load(98, 8'hFF, 2'b10, 2'b11, 1'b0);
        tick();
        async_reset("rst_full");

        load(98, 8'hFF, 2'b00, 2'b10, 1'b0);
        rd(10'd0, 1'b1);
        rd(10'd391, 1'b1);
        rd(10'd783, 1'b1);
        rd(10'd784, 1'b0);

        tick();
        tick();
        chk("sb_drained", {2'b00, (qq.size() == 0 && sq.size() == 0)}, 3'b001);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_frame_loader.md
INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

Interface
REQ-001 Parameter DATA_W, default 8, width of each loaded word in bits.
REQ-002 Parameter NUM_BITS, default 784, bits per frame; SHALL be an integer multiple of DATA_W (WORDS = NUM_BITS/DATA_W, 98 at defaults).
REQ-003 Parameter ADDR_W, default 10, read address width; SHALL satisfy 2^ADDR_W >= NUM_BITS.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 trigger  input  1  one-cycle strobe: data is a valid word this cycle.
REQ-007 data  input  DATA_W  word to store when trigger=1.
REQ-008 abort  input  1  discard the partially loaded frame in the write bank.
REQ-009 release  input  1  one-cycle strobe from consumer: current read bank is consumed.
REQ-010 addr  input  ADDR_W  bit address into the current read bank.
REQ-011 q  output  1  registered bit read at addr.
REQ-012 ready  output  1  at least one complete frame is held.
REQ-013 full  output  1  both banks hold complete frames.
REQ-014 overflow  output  1  one-cycle pulse: trigger dropped because full=1.

Function
REQ-015 Storage SHALL be two banks (0,1) of WORDS x DATA_W; wr_bank selects the bank being filled, rd_bank the bank read via addr.
REQ-016 Word counter wcnt (0..WORDS-1): trigger=1 and full=0 writes data to word wcnt of wr_bank, then wcnt increments.
REQ-017 Bit mapping SHALL be LSB-first: word k bit j appears at addr k*DATA_W+j.
REQ-018 On the write of word WORDS-1: wcnt -> 0, wr_bank toggles, frame count fcnt (0..2) increments; ready rises the next cycle.
REQ-019 ready = (fcnt>0); full = (fcnt==2); both registered from fcnt.
REQ-020 trigger=1 while full=1 SHALL write nothing, leave wcnt unchanged, and pulse overflow for exactly one cycle.
REQ-021 release=1 with fcnt>0: fcnt decrements, rd_bank toggles; release with fcnt==0 SHALL be ignored.
REQ-022 Frame completion and release in the same cycle: fcnt unchanged, both wr_bank and rd_bank toggle.
REQ-023 abort=1: wcnt -> 0, already-written words of the partial frame are treated as garbage and overwritten; fcnt, rd_bank unaffected; abort has priority over a simultaneous trigger (word dropped, no overflow).
REQ-024 q SHALL equal bit addr of rd_bank one cycle after addr is presented (1-cycle latency); addr >= NUM_BITS gives q=0.
REQ-025 q SHALL follow rd_bank as of the read edge; a release in the same cycle affects q from the following read.
REQ-026 No ready to trigger handshake: producer may trigger every cycle; back-to-back frames SHALL load with no gap cycles.

Reset
REQ-027 rst_n=0 SHALL asynchronously force wcnt=0, fcnt=0, wr_bank=0, rd_bank=0, q=0, ready=0, full=0, overflow=0.
REQ-028 Bank contents are not reset; reset mid-frame discards the partial frame and any complete frames.
REQ-029 Outputs SHALL remain at reset values while rst_n=0 regardless of trigger, abort, release.

Verification
REQ-030 Defaults; 98 triggers of 8'hFF, one per cycle -> ready=0 through word 97, ready=1 the cycle after word 97; addr 0..783 each returns q=1 one cycle later.
REQ-031 98 words of 8'hA5 -> q at addr 0,1,2,5,7 = 1,0,1,1,1 and addr 8 = 1, addr 784 = 0.
REQ-032 Load frame A (8'h00) then frame B (8'hFF) without release -> full=1; 99th further trigger -> overflow pulses once, wcnt unchanged; q still reads A (0); release -> full=0, ready=1, q reads B (1).
REQ-033 Load 50 words, assert abort, load 98 words of 8'h0F -> ready after exactly the 98 post-abort words; addr 4..7 read 0, addr 0..3 read 1.
REQ-034 fcnt=1 with frame-completing trigger and release in same cycle -> ready stays 1, full stays 0, q reads new frame next read.
REQ-035 rst_n pulsed low mid-frame and with full=1 -> all outputs 0 immediately (asynchronous); subsequent 98 triggers produce ready exactly as in REQ-030.
